// File: rtl/pll_lock_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_reset_seq
// Brief    : Qualifies an asynchronous PLL lock flag, sequences the system
//            reset release and the SDRAM power-up wait, counts lock losses.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES         = 2,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int RESET_HOLD_CYCLES   = 16,
    parameter int POWERUP_WAIT_CYCLES = 20000,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked_in,
    output logic                  rst_out,
    output logic                  sdram_init_ok,
    output logic [LOSS_CNT_W-1:0] lock_lost_cnt,
    output logic [1:0]            seq_state
);

    localparam int CNT_MAX_A = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > POWERUP_WAIT_CYCLES) ?
                               CNT_MAX_A : POWERUP_WAIT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]      PU_DONE     = CNT_W'(POWERUP_WAIT_CYCLES);
    localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_ONE    = LOSS_CNT_W'(1);
    localparam logic [LOSS_CNT_W-1:0] LOSS_SAT    = {LOSS_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q, sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    rst_out_q, rst_out_d;
    logic                    init_ok_q, init_ok_d;
    logic [LOSS_CNT_W-1:0]   lock_lost_cnt_q, lock_lost_cnt_d;
    logic                    locked_s;

    // locked_in is asynchronous; only the first synchroniser stage samples it.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], locked_in};
    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= WAIT_LOCK;
            sync_q          <= '0;
            cnt_q           <= '0;
            rst_out_q       <= 1'b1;
            init_ok_q       <= 1'b0;
            lock_lost_cnt_q <= '0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            cnt_q           <= cnt_d;
            rst_out_q       <= rst_out_d;
            init_ok_q       <= init_ok_d;
            lock_lost_cnt_q <= lock_lost_cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rst_out_d       = 1'b1;
        init_ok_d       = 1'b0;
        lock_lost_cnt_d = lock_lost_cnt_q;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    rst_out_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    if (lock_lost_cnt_q != LOSS_SAT) begin
                        lock_lost_cnt_d = lock_lost_cnt_q + LOSS_ONE;
                    end
                end else begin
                    rst_out_d = 1'b0;
                    // Counter parks at the terminal value so init_ok stays high.
                    if (cnt_q != PU_DONE) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    init_ok_d = (cnt_d == PU_DONE);
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    assign rst_out       = rst_out_q;
    assign sdram_init_ok = init_ok_q;
    assign lock_lost_cnt = lock_lost_cnt_q;
    assign seq_state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_reset_seq
// Brief    : Self-checking bench; reference model tracks the run length of
//            consecutive qualified lock samples and derives every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_reset_seq;

    localparam int SYNC_STAGES = 2;
    localparam int LOCK_STABLE = 8;
    localparam int RESET_HOLD  = 4;
    localparam int PU_WAIT     = 10;
    localparam int LOSS_W      = 2;
    localparam int RUN_K       = LOCK_STABLE + RESET_HOLD + 1;
    localparam int LOSS_MAX    = (1 << LOSS_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              locked_in = 1'b0;
    logic              rst_out;
    logic              sdram_init_ok;
    logic [LOSS_W-1:0] lock_lost_cnt;
    logic [1:0]        seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: sampled-lock history and the length of the current run of
    // consecutive high samples the sequencer has observed.
    bit hist[SYNC_STAGES];
    int run_len;
    int lost;

    pll_lock_reset_seq #(
        .SYNC_STAGES        (SYNC_STAGES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE),
        .RESET_HOLD_CYCLES  (RESET_HOLD),
        .POWERUP_WAIT_CYCLES(PU_WAIT),
        .LOSS_CNT_W         (LOSS_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .locked_in    (locked_in),
        .rst_out      (rst_out),
        .sdram_init_ok(sdram_init_ok),
        .lock_lost_cnt(lock_lost_cnt),
        .seq_state    (seq_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_state();
        if (run_len == 0)                       return 0;
        if (run_len <= LOCK_STABLE)             return 1;
        if (run_len <= LOCK_STABLE + RESET_HOLD) return 2;
        return 3;
    endfunction

    task automatic check_all();
        chk("rst_out",       32'(rst_out),       32'(run_len < RUN_K));
        chk("sdram_init_ok", 32'(sdram_init_ok), 32'(run_len >= RUN_K + PU_WAIT));
        chk("lock_lost_cnt", 32'(lock_lost_cnt), 32'(lost));
        chk("seq_state",     32'(seq_state),     32'(exp_state()));
    endtask

    task automatic model_reset();
        for (int i = 0; i < SYNC_STAGES; i++) hist[i] = 1'b0;
        run_len = 0;
        lost    = 0;
    endtask

    task automatic model_edge(input bit lk);
        bit seen;
        seen = hist[SYNC_STAGES-1];
        for (int i = SYNC_STAGES - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = lk;
        if (seen) begin
            if (run_len < 100000) run_len++;
        end else begin
            if (run_len >= RUN_K && lost < LOSS_MAX) lost++;
            run_len = 0;
        end
    endtask

    task automatic step(input bit lk);
        locked_in = lk;
        @(posedge clk);
        model_edge(lk);
        #1;
        check_all();
    endtask

    // Reset lands between clock edges; outputs must respond without an edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    // Holds lock high for n edges; checks rst_out/sdram_init_ok edge counts.
    task automatic bring_up(input int n);
        for (int e = 1; e <= n; e++) begin
            step(1'b1);
            if (e == 14) chk("latency rst_out pre",  32'(rst_out), 32'd1);
            if (e == 15) chk("latency rst_out",      32'(rst_out), 32'd0);
            if (e == 24) chk("latency init_ok pre",  32'(sdram_init_ok), 32'd0);
            if (e == 25) chk("latency init_ok",      32'(sdram_init_ok), 32'd1);
        end
    endtask

    initial begin
        int exp_sat[4] = '{1, 2, 3, 3};
        int hi_len, lo_len;

        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        check_all();

        // Clean bring-up with explicit state sequence points
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int e = 1; e <= 25; e++) begin
            step(1'b1);
            if (e == 2)  chk("seq wait",   32'(seq_state), 32'd0);
            if (e == 3)  chk("seq stable", 32'(seq_state), 32'd1);
            if (e == 11) chk("seq hold",   32'(seq_state), 32'd2);
            if (e == 15) chk("seq run",    32'(seq_state), 32'd3);
            if (e == 14) chk("t1 rst_out pre", 32'(rst_out), 32'd1);
            if (e == 15) chk("t1 rst_out",     32'(rst_out), 32'd0);
            if (e == 25) chk("t1 init_ok",     32'(sdram_init_ok), 32'd1);
        end

        // Chatter in STABLE
        async_reset();
        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);
        step(1'b0);
        bring_up(25);
        chk("t2 lost", 32'(lock_lost_cnt), 32'd0);

        // Drop in RUN, then relock
        step(1'b0);
        step(1'b0);
        chk("t3 rst_out before", 32'(rst_out), 32'd0);
        step(1'b0);
        chk("t3 rst_out", 32'(rst_out), 32'd1);
        chk("t3 init_ok", 32'(sdram_init_ok), 32'd0);
        chk("t3 lost",    32'(lock_lost_cnt), 32'd1);
        chk("t3 state",   32'(seq_state), 32'd0);
        bring_up(25);

        // Saturation
        async_reset();
        for (int d = 0; d < 4; d++) begin
            bring_up(25);
            for (int i = 0; i < 3; i++) step(1'b0);
            chk("t4 sat", 32'(lock_lost_cnt), 32'(exp_sat[d]));
        end

        // Async reset mid-HOLD with nonzero loss count
        bring_up(12);
        chk("t5 in hold", 32'(seq_state), 32'd2);
        async_reset();
        chk("t5 rst_out", 32'(rst_out), 32'd1);
        chk("t5 state",   32'(seq_state), 32'd0);
        chk("t5 lost",    32'(lock_lost_cnt), 32'd0);
        bring_up(25);

        // Drop during power-up wait (cnt=5)
        async_reset();
        for (int e = 1; e <= 20; e++) step(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            chk("t6 init_ok", 32'(sdram_init_ok), 32'd0);
        end
        chk("t6 lost",    32'(lock_lost_cnt), 32'd1);
        chk("t6 rst_out", 32'(rst_out), 32'd1);

        // Randomised lock activity
        for (int s = 0; s < 60; s++) begin
            hi_len = $urandom_range(1, 30);
            lo_len = $urandom_range(1, 4);
            for (int i = 0; i < hi_len; i++) step(1'b1);
            for (int i = 0; i < lo_len; i++) step(1'b0);
            if ($urandom_range(0, 9) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
